// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types and core-wide stage constants.
// Imported by every *_stage register and by core top-level wiring.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } stage_state_e;

  localparam int IFID_DATA_W = 96;

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating event counter with synchronous clear.
// Shared by the stage stall monitor and other perf counters.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic valid/ready pipeline-stage register with optional skid entry,
// flush-to-bubble and a saturating backpressure-cycle counter.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int               DATA_W      = 96,
  parameter bit               ENABLE_SKID = 1'b1,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
  parameter int               CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cycles
);

  stage_state_e      state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              acc, tkn;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;

  // With a skid entry in_ready depends only on state, so no
  // combinational path runs from out_ready back upstream.
  generate
    if (ENABLE_SKID) begin : g_skid
      assign in_ready = (state_q != ST_SKID);
    end else begin : g_noskid
      assign in_ready = (state_q == ST_EMPTY) | out_ready;
    end
  endgenerate

  assign acc = in_valid & in_ready;
  assign tkn = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (acc) begin
          state_d = ST_FULL;
          main_d  = in_data;
        end
      end
      ST_FULL: begin
        if (tkn && acc) begin
          main_d = in_data;
        end else if (tkn) begin
          state_d = ST_EMPTY;
        end else if (acc && ENABLE_SKID) begin
          state_d = ST_SKID;
          skid_d  = in_data;
        end
      end
      ST_SKID: begin
        if (tkn) begin
          state_d = ST_FULL;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state_q <= ST_EMPTY;
      main_q  <= BUBBLE_VAL;
      skid_q  <= BUBBLE_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Counted on the pre-flush view; only reset clears it.
  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .clr  (reset),
    .inc  (out_valid & ~out_ready),
    .count(stall_cycles)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid (skid, saturation,
// and single-entry variants).
module tb_pipe_stage_skid;

  localparam logic [15:0] BUB = 16'hDEAD;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        in_valid, out_ready;
  logic [15:0] in_data;

  logic        s_in_ready, s_out_valid;
  logic [15:0] s_out_data;
  logic [15:0] s_stall;

  logic        c_in_ready, c_out_valid;
  logic [15:0] c_out_data;
  logic [3:0]  c_stall;

  logic        n_in_valid, n_out_ready;
  logic [15:0] n_in_data;
  logic        n_in_ready, n_out_valid;
  logic [15:0] n_out_data;
  logic [15:0] n_stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(
    .DATA_W(16), .ENABLE_SKID(1'b1), .BUBBLE_VAL(BUB), .CNT_W(16)
  ) u_skid (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .stall_cycles(s_stall)
  );

  pipe_stage_skid #(
    .DATA_W(16), .ENABLE_SKID(1'b1), .BUBBLE_VAL(BUB), .CNT_W(4)
  ) u_sat (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(c_in_ready), .in_data(in_data),
    .out_valid(c_out_valid), .out_ready(out_ready), .out_data(c_out_data),
    .stall_cycles(c_stall)
  );

  pipe_stage_skid #(
    .DATA_W(16), .ENABLE_SKID(1'b0), .BUBBLE_VAL(BUB), .CNT_W(16)
  ) u_ns (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(n_in_valid), .in_ready(n_in_ready), .in_data(n_in_data),
    .out_valid(n_out_valid), .out_ready(n_out_ready), .out_data(n_out_data),
    .stall_cycles(n_stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] q[$];
    logic        mv;
    logic        acc, tkn;
    logic [15:0] seq;
    int          exp_sat;

    reset = 1'b1; flush = 1'b0;
    in_valid = 1'b1; in_data = 16'h0055; out_ready = 1'b0;
    n_in_valid = 1'b0; n_in_data = '0; n_out_ready = 1'b0;

    // 1: reset with in_valid high
    step(); step();
    chk("rst_out_valid", {31'd0, s_out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, s_in_ready}, 32'd1);
    chk("rst_out_data", {16'd0, s_out_data}, {16'd0, BUB});
    chk("rst_stall", {16'd0, s_stall}, 32'd0);
    chk("rst_ns_in_ready", {31'd0, n_in_ready}, 32'd1);
    reset = 1'b0; in_valid = 1'b0;
    step();
    chk("idle_out_valid", {31'd0, s_out_valid}, 32'd0);

    // 2: back-to-back streaming
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      in_data = 16'(i);
      #1;
      chk("strm_in_ready", {31'd0, s_in_ready}, 32'd1);
      step();
      chk("strm_out_valid", {31'd0, s_out_valid}, 32'd1);
      chk("strm_out_data", {16'd0, s_out_data}, i);
    end
    in_valid = 1'b0;
    step();
    chk("strm_drain", {31'd0, s_out_valid}, 32'd0);
    chk("strm_stall", {16'd0, s_stall}, 32'd0);

    // 3: backpressure fills skid, then drains in order
    in_valid = 1'b1; in_data = 16'd1; out_ready = 1'b1;
    step();
    out_ready = 1'b0; in_data = 16'd2;
    step();
    in_data = 16'd3;
    step(); step(); step();
    chk("bp_main", {16'd0, s_out_data}, 32'd1);
    chk("bp_skid", {16'd0, u_skid.skid_q}, 32'd2);
    chk("bp_in_ready", {31'd0, s_in_ready}, 32'd0);
    chk("bp_stall", {16'd0, s_stall}, 32'd4);
    out_ready = 1'b1;
    step();
    chk("bp_out2", {16'd0, s_out_data}, 32'd2);
    chk("bp_in_ready_back", {31'd0, s_in_ready}, 32'd1);
    chk("bp_stall_hold", {16'd0, s_stall}, 32'd4);
    step();
    chk("bp_out3_valid", {31'd0, s_out_valid}, 32'd1);
    chk("bp_out3", {16'd0, s_out_data}, 32'd3);
    in_valid = 1'b0;
    step();
    chk("bp_empty", {31'd0, s_out_valid}, 32'd0);

    // 4: flush while holding two entries
    in_valid = 1'b1; in_data = 16'h0011; out_ready = 1'b0;
    step();
    in_data = 16'h0022;
    step();
    chk("fl_pre_in_ready", {31'd0, s_in_ready}, 32'd0);
    flush = 1'b1; in_data = 16'h00AA;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", {31'd0, s_out_valid}, 32'd0);
    chk("fl_out_data", {16'd0, s_out_data}, {16'd0, BUB});
    chk("fl_in_ready", {31'd0, s_in_ready}, 32'd1);
    chk("fl_stall_kept", {16'd0, s_stall}, 32'd6);
    out_ready = 1'b1;
    step();
    chk("fl_no_aa", {31'd0, s_out_valid}, 32'd0);

    // 5: 4-bit counter saturation
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("sat_rst", {28'd0, c_stall}, 32'd0);
    in_valid = 1'b1; in_data = 16'h0033; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      exp_sat = (i > 15) ? 15 : i;
      chk("sat_cnt", {28'd0, c_stall}, exp_sat);
    end
    chk("sat_wide", {16'd0, s_stall}, 32'd20);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("sat_flush_kept", {28'd0, c_stall}, 32'd15);
    chk("sat_flush_wide", {16'd0, s_stall}, 32'd21);
    chk("sat_flush_empty", {31'd0, c_out_valid}, 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("sat_reset_clr", {28'd0, c_stall}, 32'd0);

    // 6: single-entry variant against a scoreboard
    mv = 1'b0; seq = 16'd1;
    for (int c = 0; c < 10000; c++) begin
      n_in_valid  = 1'($urandom_range(0, 1));
      n_out_ready = 1'($urandom_range(0, 1));
      n_in_data   = n_in_valid ? seq : 16'hxxxx;
      #1;
      chk("ns_out_valid", {31'd0, n_out_valid}, {31'd0, mv});
      chk("ns_in_ready", {31'd0, n_in_ready}, {31'd0, ~mv | n_out_ready});
      if (mv) chk("ns_out_data", {16'd0, n_out_data}, {16'd0, q[0]});
      tkn = mv & n_out_ready;
      acc = n_in_valid & (~mv | n_out_ready);
      if (tkn) void'(q.pop_front());
      if (acc) begin
        q.push_back(seq);
        seq = seq + 16'd1;
      end
      mv = (q.size() != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
